pattern_sequencer: RTL and testbench

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

---
 rtl/pattern_sequencer.sv | 123 ++++++++++++
 tb/tb_pattern_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sequencer.sv
// Button-driven test-pattern selector with debounced inputs,
// frame-synchronous commits and an auto-advance mode.
module pattern_sequencer #(
   parameter int NUM_PATTERNS    = 9,
   parameter int RESET_PATTERN   = 1,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int AUTO_FRAMES     = 120
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_btn_next,
   input  logic       i_btn_prev,
   input  logic       i_btn_mode,
   input  logic       i_frame_strobe,
   output logic [3:0] o_pattern,
   output logic       o_auto,
   output logic       o_change_strobe
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int FW = $clog2(AUTO_FRAMES + 1);
   localparam logic [3:0] LAST = 4'(NUM_PATTERNS - 1);
   localparam logic [3:0] RST_PAT = 4'(RESET_PATTERN);
   localparam logic [DW-1:0] DB_END = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [FW-1:0] FR_END = FW'(AUTO_FRAMES - 1);

   typedef enum logic {MANUAL, AUTO} state_t;

   state_t state_q, state_d;

   logic [2:0]    raw;
   logic [2:0]    stable_q;
   logic [2:0]    press_q;
   logic [DW-1:0] cnt_q [3];

   logic [3:0]    tgt_q, tgt_d;
   logic [3:0]    pat_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          chg_d;
   logic          nx, pv;
   logic          advance;
   logic [3:0]    adv_val;

   assign raw = {i_btn_mode, i_btn_prev, i_btn_next};

   // press_q pulses in the first cycle the stable level shows a rise
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         stable_q <= '0;
         press_q  <= '0;
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            press_q[i] <= 1'b0;
            if (raw[i] == stable_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == DB_END) begin
               stable_q[i] <= raw[i];
               cnt_q[i]    <= '0;
               press_q[i]  <= raw[i];
            end else begin
               cnt_q[i] <= cnt_q[i] + DW'(1);
            end
         end
      end
   end

   assign nx = press_q[0] & ~press_q[1];
   assign pv = press_q[1] & ~press_q[0];

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      pat_d   = o_pattern;
      fcnt_d  = fcnt_q;
      chg_d   = 1'b0;
      adv_val = (o_pattern >= LAST) ? 4'd1 : o_pattern + 4'd1;
      advance = (state_q == AUTO) && i_frame_strobe && (fcnt_q == FR_END);

      if (press_q[2])
         state_d = (state_q == MANUAL) ? AUTO : MANUAL;

      if (nx)
         tgt_d = (tgt_q == LAST) ? 4'd0 : tgt_q + 4'd1;
      else if (pv)
         tgt_d = (tgt_q == 4'd0) ? LAST : tgt_q - 4'd1;

      // auto advance overrides the pending manual target
      if (advance) begin
         pat_d = adv_val;
         tgt_d = adv_val;
      end else if (i_frame_strobe) begin
         pat_d = tgt_q;
      end
      chg_d = i_frame_strobe && (pat_d != o_pattern);

      if (state_q != AUTO)
         fcnt_d = '0;
      else if (nx || pv || advance)
         fcnt_d = '0;
      else if (i_frame_strobe)
         fcnt_d = fcnt_q + FW'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q         <= MANUAL;
         tgt_q           <= RST_PAT;
         o_pattern       <= RST_PAT;
         fcnt_q          <= '0;
         o_auto          <= 1'b0;
         o_change_strobe <= 1'b0;
      end else begin
         state_q         <= state_d;
         tgt_q           <= tgt_d;
         o_pattern       <= pat_d;
         fcnt_q          <= fcnt_d;
         o_auto          <= (state_d == AUTO);
         o_change_strobe <= chg_d;
      end
   end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: directed scenarios then random
// button/strobe traffic against a frame-level reference model.
module tb_pattern_sequencer;

   localparam int NP = 9;
   localparam int RP = 1;
   localparam int DB = 4;
   localparam int AF = 3;

   logic       i_clk = 1'b0;
   logic       i_reset = 1'b0;
   logic       i_btn_next = 1'b0;
   logic       i_btn_prev = 1'b0;
   logic       i_btn_mode = 1'b0;
   logic       i_frame_strobe = 1'b0;
   logic [3:0] o_pattern;
   logic       o_auto;
   logic       o_change_strobe;

   int checks = 0;
   int failures = 0;
   int nchg = 0;

   // reference model state
   int m_pat, m_tgt, m_fc;
   bit m_auto, m_chg;
   bit m_lvl [3];
   int m_run [3];
   bit m_pr  [3];

   pattern_sequencer #(
      .NUM_PATTERNS(NP),
      .RESET_PATTERN(RP),
      .DEBOUNCE_CYCLES(DB),
      .AUTO_FRAMES(AF)
   ) dut (
      .i_clk(i_clk),
      .i_reset(i_reset),
      .i_btn_next(i_btn_next),
      .i_btn_prev(i_btn_prev),
      .i_btn_mode(i_btn_mode),
      .i_frame_strobe(i_frame_strobe),
      .o_pattern(o_pattern),
      .o_auto(o_auto),
      .o_change_strobe(o_change_strobe)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic model(input bit r, input bit n, input bit p,
                        input bit m, input bit s);
      bit raw [3];
      bit en, ep, adv;
      int nt, npat;
      raw[0] = n; raw[1] = p; raw[2] = m;
      if (r) begin
         m_pat = RP; m_tgt = RP; m_fc = 0;
         m_auto = 0; m_chg = 0;
         for (int i = 0; i < 3; i++) begin
            m_lvl[i] = 0; m_run[i] = 0; m_pr[i] = 0;
         end
         return;
      end
      en = m_pr[0] && !m_pr[1];
      ep = m_pr[1] && !m_pr[0];
      nt = m_tgt;
      if (en) nt = (m_tgt + 1) % NP;
      if (ep) nt = (m_tgt + NP - 1) % NP;
      adv = m_auto && s && (m_fc == AF - 1);
      npat = m_pat;
      if (adv) begin
         npat = (m_pat % (NP - 1)) + 1;
         nt = npat;
      end else if (s) begin
         npat = m_tgt;
      end
      m_chg = s && (npat != m_pat);
      if (!m_auto || en || ep || adv) m_fc = 0;
      else if (s) m_fc = m_fc + 1;
      if (m_pr[2]) m_auto = !m_auto;
      m_pat = npat;
      m_tgt = nt;
      // a level is accepted after DB consecutive differing samples
      for (int i = 0; i < 3; i++) begin
         m_pr[i] = 0;
         if (raw[i] == m_lvl[i]) m_run[i] = 0;
         else m_run[i] = m_run[i] + 1;
         if (m_run[i] == DB) begin
            m_lvl[i] = raw[i];
            m_run[i] = 0;
            m_pr[i] = raw[i];
         end
      end
   endtask

   task automatic tick(input bit r, input bit n, input bit p,
                       input bit m, input bit s);
      i_reset = r; i_btn_next = n; i_btn_prev = p;
      i_btn_mode = m; i_frame_strobe = s;
      @(posedge i_clk);
      model(r, n, p, m, s);
      #1;
      if (o_change_strobe === 1'b1) nchg++;
      chk("pattern", int'(o_pattern), m_pat);
      chk("auto", int'(o_auto), int'(m_auto));
      chk("change", int'(o_change_strobe), int'(m_chg));
      chk("range", int'(o_pattern < 4'(NP)), 1);
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) tick(0, 0, 0, 0, 0);
   endtask

   task automatic press(input int b);
      for (int i = 0; i < 6; i++) tick(0, b == 0, b == 1, b == 2, 0);
      idle(6);
   endtask

   task automatic strobe();
      tick(0, 0, 0, 0, 1);
      idle(2);
   endtask

   initial begin
      bit n, p, m;
      int hn, hp, hm;

      tick(1, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
      chk("rst_pat", int'(o_pattern), 1);
      chk("rst_auto", int'(o_auto), 0);
      chk("rst_chg", int'(o_change_strobe), 0);

      // held next, commit on strobe
      for (int i = 0; i < 10; i++) tick(0, 1, 0, 0, 0);
      idle(6);
      chk("hold_pre", int'(o_pattern), 1);
      nchg = 0;
      tick(0, 0, 0, 0, 1);
      chk("hold_commit", int'(o_pattern), 2);
      idle(3);
      chk("hold_chg_cnt", nchg, 1);

      // bouncing button never settles
      for (int i = 0; i < 8; i++) tick(0, (i % 2) == 0, 0, 0, 0);
      idle(6);
      strobe();
      strobe();
      chk("bounce", int'(o_pattern), 2);

      // wrap both directions
      for (int i = 0; i < 6; i++) press(0);
      strobe();
      chk("to8", int'(o_pattern), 8);
      press(0);
      strobe();
      chk("wrap_up", int'(o_pattern), 0);
      press(1);
      strobe();
      chk("wrap_dn", int'(o_pattern), 8);

      // accumulate presses between strobes
      press(0);
      press(0);
      strobe();
      chk("to1", int'(o_pattern), 1);
      nchg = 0;
      press(0);
      press(0);
      press(0);
      strobe();
      chk("accum", int'(o_pattern), 4);
      chk("accum_chg", nchg, 1);

      // press coincident with strobe lands at the following strobe
      for (int i = 0; i < 12; i++) tick(0, i < 6, 0, 0, m_pr[0]);
      chk("coinc_hold", int'(o_pattern), 4);
      strobe();
      chk("coinc_commit", int'(o_pattern), 5);

      // auto mode from pattern 6
      press(0);
      strobe();
      chk("to6", int'(o_pattern), 6);
      press(2);
      chk("auto_on", int'(o_auto), 1);
      for (int k = 1; k <= 9; k++) begin
         strobe();
         if (k == 3) chk("auto_s3", int'(o_pattern), 7);
         if (k == 6) chk("auto_s6", int'(o_pattern), 8);
         if (k == 9) chk("auto_s9", int'(o_pattern), 1);
      end
      press(2);
      chk("auto_off", int'(o_auto), 0);
      strobe();
      chk("manual_hold", int'(o_pattern), 1);

      // reset during auto with pending target 5
      press(2);
      for (int k = 0; k < 3; k++) strobe();
      chk("auto_adv2", int'(o_pattern), 2);
      press(0);
      press(0);
      press(0);
      nchg = 0;
      tick(1, 0, 0, 0, 0);
      chk("rst_auto_pat", int'(o_pattern), 1);
      chk("rst_auto_mode", int'(o_auto), 0);
      chk("rst_auto_chg", nchg, 0);

      // button held through reset release
      tick(1, 1, 0, 0, 0);
      for (int i = 0; i < 8; i++) tick(0, 1, 0, 0, 0);
      idle(6);
      strobe();
      chk("held_rst", int'(o_pattern), 2);

      // random traffic
      hn = 0; hp = 0; hm = 0;
      n = 0; p = 0; m = 0;
      for (int c = 0; c < 4000; c++) begin
         if (hn == 0) begin n = 1'($urandom_range(0, 1)); hn = $urandom_range(1, 9); end
         if (hp == 0) begin p = 1'($urandom_range(0, 1)); hp = $urandom_range(1, 9); end
         if (hm == 0) begin
            m = ($urandom_range(0, 3) == 0);
            hm = $urandom_range(1, 12);
         end
         hn--; hp--; hm--;
         tick($urandom_range(0, 399) == 0, n, p, m,
              $urandom_range(0, 4) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
